hazard3_regfile_2wnr: RTL and testbench
=======================================

// Module: hazard3_regfile_2wnr
// PURPOSE
//  Generalised register file: two write ports, N_RPORTS registered read ports.
//  Optional same-cycle write-to-read bypass and hardwired-zero x0.
//  Post-reset hardware clear sequencer zeroes storage, which itself has no reset, so it stays RAM-inferable.
//  Sits beside the decode/writeback stages for dual-issue or separate load/ALU writeback cores.
// PARAMETERS
//  N_REGS         32               number of registers
//  W_DATA         32               register width
//  W_ADDR         $clog2(N_REGS)   address width (treat as localparam)
//  N_RPORTS       2                read port count, >=1
//  ZERO_REG0      1                1: reg 0 reads 0, writes to it dropped
//  BYPASS         1                1: same-cycle write forwarded to read data
//  CLEAR_ON_RESET 1                1: run clear sequence after reset
// PORTS
//  clk       in   1                  clock
//  rst_n     in   1                  async reset, active low
//  ren       in   N_RPORTS           per-port read enable
//  raddr     in   N_RPORTS*W_ADDR    read addresses, port k at [k*W_ADDR +: W_ADDR]
//  rdata     out  N_RPORTS*W_DATA    read data, port k at [k*W_DATA +: W_DATA]
//  wen0      in   1                  write port 0 enable
//  waddr0    in   W_ADDR             write port 0 address
//  wdata0    in   W_DATA             write port 0 data
//  wen1      in   1                  write port 1 enable (higher priority)
//  waddr1    in   W_ADDR             write port 1 address
//  wdata1    in   W_DATA             write port 1 data
//  clr_busy  out  1                  clear sequence in progress; core must stall
// BEHAVIOUR
//  Clock and reset: one clock clk; reset rst_n is asynchronous, active low.
//  Reset values: rdata all 0. clr_busy = CLEAR_ON_RESET. Clear counter = 0. Storage not reset.
//  Clear FSM has two states, CLEAR and IDLE.
//   - Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
//   - In CLEAR: write 0 to mem[cnt] each cycle. cnt 0..N_REGS-1, then go to IDLE.
//   - clr_busy is high for exactly N_REGS cycles after rst_n deassertion.
//   - rst_n asserted mid-clear restarts from cnt=0.
//  During CLEAR:
//   - wen0 and wen1 are ignored.
//   - Any port with ren=1 loads rdata with 0.
//  Read path:
//   - Registered; data appears one cycle after ren=1.
//   - ren=0 holds the previous rdata.
//   - raddr >= N_REGS reads 0.
//   - ZERO_REG0: raddr==0 reads 0.
//  Write path:
//   - Committed at posedge.
//   - Both ports may write in the same cycle. If waddr0==waddr1, port 1's data is stored.
//   - ZERO_REG0: writes to address 0 are dropped.
//   - Writes to addresses >= N_REGS are dropped.
//  Bypass, BYPASS=1: if ren[k] and a valid write in the same cycle targets raddr[k], rdata[k] <= that wdata.
//   - Port 1 has priority over port 0.
//   - No bypass for dropped writes (reg 0, out of range, during CLEAR).
//  Bypass, BYPASS=0: read-before-write; the old value is returned.
//  Reads on all ports are independent. Duplicate read addresses are legal.
// STRUCTURE
//  Shared header hazard3_regfile_defs.vh contains:
//   - clear FSM state encodings (IDLE, CLEAR)
//   - helper macro for flattened port slicing
//  Sub-module hazard3_regfile_rport contains:
//   - one read port: address range check, zero-reg check, bypass mux, rdata register with ren hold
//   - generated N_RPORTS times
//  Top level contains: storage array, write arbitration, clear FSM/counter.
// TESTING
//  1. Release reset, N_REGS=32: clr_busy high exactly 32 cycles. ren=1 on every register afterwards reads 0.
//  2. wen0 to reg 5 = 0xDEADBEEF. Next cycle ren[0]=1, raddr=5: rdata[0]=0xDEADBEEF one cycle later.
//  3. Same cycle: wen0 reg 7 = 0x11, wen1 reg 7 = 0x22, ren[1]=1 raddr 7.
//     - BYPASS=1: rdata[1]=0x22.
//     - Following read also returns 0x22.
//     - BYPASS=0: rdata[1] is the old value.
//  4. wen1 reg 0 = 0xFFFFFFFF with ZERO_REG0=1, bypass active: reads of reg 0 return 0, both same cycle and later.
//  5. Hold ren=0 while writing raddr's register: rdata unchanged. Then ren=1: rdata returns the new value.
//  6. Assert rst_n at cnt=10 mid-clear: rdata goes to 0 at once. After deassert, clr_busy lasts a full 32 cycles.
//     A write issued during clear is lost.

Source files
------------

// File: rtl/hazard3_regfile_2wnr_pkg.sv
// Shared types and helpers for the dual-write, multi-read register file.
package hazard3_regfile_2wnr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned DEF_N_REGS   = 32;
  localparam int unsigned DEF_W_DATA   = 32;
  localparam int unsigned DEF_N_RPORTS = 2;

  // Address width for a register count; a single register still gets one bit.
  function automatic int unsigned addr_bits(input int unsigned n_regs);
    return (n_regs > 1) ? $clog2(n_regs) : 1;
  endfunction

endpackage

// File: rtl/hazard3_regfile_2wnr_if.sv
// Read/write port bundle between the core pipeline (master) and the register file (slave).
interface hazard3_regfile_2wnr_if
  import hazard3_regfile_2wnr_pkg::*;
#(
  parameter int unsigned N_RPORTS = DEF_N_RPORTS,
  parameter int unsigned W_ADDR   = addr_bits(DEF_N_REGS),
  parameter int unsigned W_DATA   = DEF_W_DATA
) ();

  logic [N_RPORTS-1:0]        ren;
  logic [N_RPORTS*W_ADDR-1:0] raddr;
  logic [N_RPORTS*W_DATA-1:0] rdata;
  logic                       wen0;
  logic [W_ADDR-1:0]          waddr0;
  logic [W_DATA-1:0]          wdata0;
  logic                       wen1;
  logic [W_ADDR-1:0]          waddr1;
  logic [W_DATA-1:0]          wdata1;
  logic                       clr_busy;

  modport master (
    output ren, raddr, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
    input  rdata, clr_busy
  );

  modport slave (
    input  ren, raddr, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
    output rdata, clr_busy
  );

endinterface

// File: rtl/hazard3_regfile_2wnr_rport.sv
// One registered read port: range and zero-register masking, write bypass, hold on ren=0.
module hazard3_regfile_2wnr_rport
  import hazard3_regfile_2wnr_pkg::*;
#(
  parameter int unsigned N_REGS    = DEF_N_REGS,
  parameter int unsigned W_ADDR    = addr_bits(DEF_N_REGS),
  parameter int unsigned W_DATA    = DEF_W_DATA,
  parameter int unsigned ZERO_REG0 = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clearing,
  input  logic              ren,
  input  logic [W_ADDR-1:0] raddr,
  input  logic [W_DATA-1:0] mem_rdata,
  input  logic              we0,
  input  logic [W_ADDR-1:0] waddr0,
  input  logic [W_DATA-1:0] wdata0,
  input  logic              we1,
  input  logic [W_ADDR-1:0] waddr1,
  input  logic [W_DATA-1:0] wdata1,
  output logic [W_DATA-1:0] rdata
);

  localparam logic [W_ADDR:0] REG_LIMIT = N_REGS[W_ADDR:0];

  logic              addr_ok_s;
  logic [W_DATA-1:0] rdata_next_s;
  logic [W_DATA-1:0] rdata_r;

  // Next read value; we0/we1 arrive already qualified, so dropped writes never forward.
  always_comb begin
    addr_ok_s    = ({1'b0, raddr} < REG_LIMIT) &&
                   !((ZERO_REG0 != 0) && (raddr == {W_ADDR{1'b0}}));
    rdata_next_s = rdata_r;
    if (!ren) begin
      rdata_next_s = rdata_r;
    end else if (clearing || !addr_ok_s) begin
      rdata_next_s = {W_DATA{1'b0}};
    end else if ((BYPASS != 0) && we1 && (waddr1 == raddr)) begin
      rdata_next_s = wdata1;
    end else if ((BYPASS != 0) && we0 && (waddr0 == raddr)) begin
      rdata_next_s = wdata0;
    end else begin
      rdata_next_s = mem_rdata;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {W_DATA{1'b0}};
    end else begin
      rdata_r <= rdata_next_s;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/hazard3_regfile_2wnr.sv
// Register file with two write ports and N_RPORTS registered read ports.
// Storage has no reset; a post-reset sequencer zeroes it while clr_busy stalls the core.
module hazard3_regfile_2wnr
  import hazard3_regfile_2wnr_pkg::*;
#(
  parameter int unsigned N_REGS         = DEF_N_REGS,
  parameter int unsigned W_DATA         = DEF_W_DATA,
  parameter int unsigned N_RPORTS       = DEF_N_RPORTS,
  parameter int unsigned ZERO_REG0      = 1,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard3_regfile_2wnr_if.slave  bus
);

  localparam int unsigned       W_ADDR    = addr_bits(N_REGS);
  localparam int unsigned       LAST_REG  = N_REGS - 1;
  localparam logic [W_ADDR-1:0] CNT_LAST  = LAST_REG[W_ADDR-1:0];
  localparam logic [W_ADDR:0]   REG_LIMIT = N_REGS[W_ADDR:0];

  logic [W_DATA-1:0] mem_r [N_REGS];
  clr_state_e        state_r;
  clr_state_e        state_next_s;
  logic [W_ADDR-1:0] cnt_r;
  logic [W_ADDR-1:0] cnt_next_s;
  logic              clr_busy_r;
  logic              clearing_s;
  logic              we0_s;
  logic              we1_s;

  assign clearing_s   = (state_r == ST_CLEAR);
  assign bus.clr_busy = clr_busy_r;

  // Write qualification: drop writes during clear, to reg 0 and beyond the array.
  always_comb begin
    we0_s = 1'b0;
    we1_s = 1'b0;
    if (!clearing_s) begin
      we0_s = bus.wen0 && ({1'b0, bus.waddr0} < REG_LIMIT) &&
              !((ZERO_REG0 != 0) && (bus.waddr0 == {W_ADDR{1'b0}}));
      we1_s = bus.wen1 && ({1'b0, bus.waddr1} < REG_LIMIT) &&
              !((ZERO_REG0 != 0) && (bus.waddr1 == {W_ADDR{1'b0}}));
    end else begin
      we0_s = 1'b0;
      we1_s = 1'b0;
    end
  end

  // Clear sequencer next-state: walk cnt over every register once, then idle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = {W_ADDR{1'b0}};
        end else begin
          cnt_next_s   = cnt_r + W_ADDR'(1'b1);
        end
      end
      ST_IDLE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = {W_ADDR{1'b0}};
      end
    endcase
  end

  // Clear sequencer state register; clr_busy is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_r      <= {W_ADDR{1'b0}};
      clr_busy_r <= (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      clr_busy_r <= (state_next_s == ST_CLEAR);
    end
  end

  // Storage, no reset; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clearing_s) begin
      mem_r[cnt_r] <= {W_DATA{1'b0}};
    end else begin
      if (we0_s) begin
        mem_r[bus.waddr0] <= bus.wdata0;
      end
      if (we1_s) begin
        mem_r[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  for (genvar k = 0; k < N_RPORTS; k++) begin : g_rport
    logic [W_ADDR-1:0] raddr_s;
    logic [W_DATA-1:0] rdata_s;

    assign raddr_s = bus.raddr[k*W_ADDR +: W_ADDR];
    assign bus.rdata[k*W_DATA +: W_DATA] = rdata_s;

    hazard3_regfile_2wnr_rport #(
      .N_REGS    (N_REGS),
      .W_ADDR    (W_ADDR),
      .W_DATA    (W_DATA),
      .ZERO_REG0 (ZERO_REG0),
      .BYPASS    (BYPASS)
    ) u_rport (
      .clk       (clk),
      .rst_n     (rst_n),
      .clearing  (clearing_s),
      .ren       (bus.ren[k]),
      .raddr     (raddr_s),
      .mem_rdata (mem_r[raddr_s]),
      .we0       (we0_s),
      .waddr0    (bus.waddr0),
      .wdata0    (bus.wdata0),
      .we1       (we1_s),
      .waddr1    (bus.waddr1),
      .wdata1    (bus.wdata1),
      .rdata     (rdata_s)
    );
  end

endmodule

// File: tb/tb_hazard3_regfile_2wnr.sv
// Directed bench for hazard3_regfile_2wnr with a per-cycle array-level reference model.
module tb_hazard3_regfile_2wnr;

  localparam int NR     = 32;
  localparam int NP     = 2;
  localparam int WA     = 5;
  localparam int WD     = 32;
  localparam int BYPASS = 1;

  typedef logic [WD-1:0] mem_t [NR];

  logic clk;
  logic rst_n;
  logic chk_on;
  int   n_vec;
  int   n_err;

  hazard3_regfile_2wnr_if #(.N_RPORTS(NP), .W_ADDR(WA), .W_DATA(WD)) bus ();

  hazard3_regfile_2wnr #(
    .N_REGS(NR), .W_DATA(WD), .N_RPORTS(NP),
    .ZERO_REG0(1), .BYPASS(BYPASS), .CLEAR_ON_RESET(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  mem_t          m_mem;
  logic [WD-1:0] m_rdata [NP];
  int            clr_left;

  function automatic mem_t apply_wr(input mem_t m,
                                    input logic w0, input logic [WA-1:0] a0, input logic [WD-1:0] d0,
                                    input logic w1, input logic [WA-1:0] a1, input logic [WD-1:0] d1);
    mem_t r;
    r = m;
    if (w0 && a0 != 5'd0) r[a0] = d0;
    if (w1 && a1 != 5'd0) r[a1] = d1;
    return r;
  endfunction

  function automatic logic [WD-1:0] rd_model(input mem_t old_m, input mem_t new_m, input logic [WA-1:0] a);
    if (a == 5'd0) return 32'd0;
    return (BYPASS != 0) ? new_m[a] : old_m[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left <= NR;
      for (int k = 0; k < NP; k++) m_rdata[k] <= 32'd0;
      for (int i = 0; i < NR; i++) m_mem[i] <= 32'd0;
    end else if (clr_left != 0) begin
      clr_left <= clr_left - 1;
      for (int k = 0; k < NP; k++) if (bus.ren[k]) m_rdata[k] <= 32'd0;
    end else begin
      for (int k = 0; k < NP; k++)
        if (bus.ren[k])
          m_rdata[k] <= rd_model(m_mem,
                                 apply_wr(m_mem, bus.wen0, bus.waddr0, bus.wdata0,
                                          bus.wen1, bus.waddr1, bus.wdata1),
                                 bus.raddr[k*WA +: WA]);
      m_mem <= apply_wr(m_mem, bus.wen0, bus.waddr0, bus.wdata0,
                        bus.wen1, bus.waddr1, bus.wdata1);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WD-1:0] rdp(input int k);
    return bus.rdata[k*WD +: WD];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NP; k++) chk($sformatf("model rdata[%0d]", k), rdp(k), m_rdata[k]);
      chk("model clr_busy", {31'd0, bus.clr_busy}, {31'd0, (clr_left != 0)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ren  = 2'b00;
    bus.wen0 = 1'b0;
    bus.wen1 = 1'b0;
  endtask

  task automatic rd(input int k, input logic [WA-1:0] a);
    bus.ren[k]            = 1'b1;
    bus.raddr[k*WA +: WA] = a;
  endtask

  task automatic wr0(input logic [WA-1:0] a, input logic [WD-1:0] d);
    bus.wen0 = 1'b1; bus.waddr0 = a; bus.wdata0 = d;
  endtask

  task automatic wr1(input logic [WA-1:0] a, input logic [WD-1:0] d);
    bus.wen1 = 1'b1; bus.waddr1 = a; bus.wdata1 = d;
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0; chk_on = 1'b0;
    bus.raddr = '0; bus.waddr0 = 5'd0; bus.wdata0 = 32'd0;
    bus.waddr1 = 5'd0; bus.wdata1 = 32'd0;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    tick(); tick();
    chk("reset rdata0", rdp(0), 32'd0);
    chk("reset rdata1", rdp(1), 32'd0);
    chk("reset clr_busy", {31'd0, bus.clr_busy}, 32'd1);

    // 1: clear lasts exactly NR cycles, then every register reads 0
    rst_n = 1'b1;
    n = 0;
    while (bus.clr_busy && n < 100) begin tick(); n++; end
    chk("clear length", n, 32'd32);
    for (int a = 0; a < NR; a += 2) begin
      rd(0, a[WA-1:0]); rd(1, a[WA-1:0] + 5'd1);
      tick();
      chk("post-clear rdata0", rdp(0), 32'd0);
      chk("post-clear rdata1", rdp(1), 32'd0);
    end
    idle();

    // 2: write then read back
    wr0(5'd5, 32'hDEADBEEF);
    tick(); idle();
    rd(0, 5'd5);
    tick(); idle();
    chk("rd after wr", rdp(0), 32'hDEADBEEF);

    // 3: colliding writes, port 1 wins and is bypassed
    wr0(5'd7, 32'h11); wr1(5'd7, 32'h22); rd(1, 5'd7);
    tick(); idle();
    chk("collide bypass", rdp(1), 32'h22);
    chk("port0 hold", rdp(0), 32'hDEADBEEF);
    rd(1, 5'd7);
    tick(); idle();
    chk("collide stored", rdp(1), 32'h22);

    // 4: reg 0 stays zero even with a bypass candidate
    wr1(5'd0, 32'hFFFFFFFF); rd(0, 5'd0); rd(1, 5'd0);
    tick(); idle();
    chk("x0 bypass p0", rdp(0), 32'd0);
    chk("x0 bypass p1", rdp(1), 32'd0);
    rd(0, 5'd0);
    tick(); idle();
    chk("x0 later", rdp(0), 32'd0);

    // top register, both ports bypassed from different writers
    wr0(5'd31, 32'hA5A5A5A5); wr1(5'd30, 32'h5A5A5A5A); rd(0, 5'd31); rd(1, 5'd30);
    tick(); idle();
    chk("bypass w0 r31", rdp(0), 32'hA5A5A5A5);
    chk("bypass w1 r30", rdp(1), 32'h5A5A5A5A);

    // 5: ren=0 holds across a write to the addressed register
    bus.raddr[0 +: WA] = 5'd5;
    wr0(5'd5, 32'h12345678);
    tick(); idle();
    chk("hold during wr", rdp(0), 32'hA5A5A5A5);
    tick();
    chk("hold after wr", rdp(0), 32'hA5A5A5A5);
    rd(0, 5'd5);
    tick(); idle();
    chk("read new value", rdp(0), 32'h12345678);

    // 6: reset clears rdata at once; reset at cnt=10 restarts the full clear
    rst_n = 1'b0;
    #1;
    chk("async rdata0", rdp(0), 32'd0);
    chk("async rdata1", rdp(1), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("busy at cnt10", {31'd0, bus.clr_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      idle();
      if (n == 20) begin
        wr0(5'd3, 32'hCAFEF00D); wr1(5'd4, 32'h0BADF00D); rd(0, 5'd3); rd(1, 5'd4);
      end
      tick(); n++;
    end
    idle();
    chk("restart clear length", n, 32'd32);
    rd(0, 5'd3); rd(1, 5'd4);
    tick(); idle();
    chk("wr during clear lost p0", rdp(0), 32'd0);
    chk("wr during clear lost p1", rdp(1), 32'd0);
    rd(0, 5'd5);
    tick(); idle();
    chk("old data cleared", rdp(0), 32'd0);

    tick(); tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
